// File: rtl/memory_responder.sv
// memory_responder
//   Target side of the core memory interface. Serves combinational reads and
//   bit-masked writes to a word RAM plus a small MMIO page holding a console
//   TX FIFO and a 64-bit machine timer with compare interrupt.
// Ports
//   clk, reset            : clock; asynchronous active-high reset
//   read_memory_address   : read address (word aligned, [1:0] ignored)
//   read_memory_data      : combinational read data
//   write_memory_address  : write address (word aligned, [1:0] ignored)
//   write_memory_data     : lane-aligned write data
//   write_memory_mask     : per-bit write mask, zero means no write
//   tx_valid/tx_data      : FIFO head towards the console sink
//   tx_ready              : sink accepts the head byte
//   timer_interrupt       : mtime >= mtimecmp (unsigned 64-bit)
module memory_responder #(
  parameter int unsigned RAM_WORDS  = 4096,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] read_memory_address,
  output logic [31:0] read_memory_data,
  input  logic [31:0] write_memory_address,
  input  logic [31:0] write_memory_data,
  input  logic [31:0] write_memory_mask,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        timer_interrupt
);

  localparam int unsigned RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [3:0] OFF_TXDATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS   = 4'h1;
  localparam logic [3:0] OFF_MTIME_LO = 4'h2;
  localparam logic [3:0] OFF_MTIME_HI = 4'h3;
  localparam logic [3:0] OFF_CMP_LO   = 4'h4;
  localparam logic [3:0] OFF_CMP_HI   = 4'h5;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] mask_v);
    return (old_v & ~mask_v) | (new_v & mask_v);
  endfunction

  // ---------------- address decode ----------------
  logic              rd_ram, rd_mmio, wr_en, wr_ram, wr_mmio;
  logic [3:0]        rd_off, wr_off;
  logic [RAM_AW-1:0] rd_idx, wr_idx;
  logic              unused_addr_bits;

  assign rd_ram  = read_memory_address < RAM_BYTES;
  assign rd_mmio = read_memory_address[31:6] == MMIO_BASE[31:6];
  assign rd_off  = read_memory_address[5:2];
  assign rd_idx  = read_memory_address[RAM_AW+1:2];
  assign wr_en   = |write_memory_mask;
  assign wr_ram  = wr_en && (write_memory_address < RAM_BYTES);
  assign wr_mmio = wr_en && (write_memory_address[31:6] == MMIO_BASE[31:6]);
  assign wr_off  = write_memory_address[5:2];
  assign wr_idx  = write_memory_address[RAM_AW+1:2];
  assign unused_addr_bits = ^{read_memory_address[1:0], write_memory_address[1:0]};

  // ---------------- RAM (no reset, contents survive reset) ----------------
  logic [31:0] ram_mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_ram)
      ram_mem[wr_idx] <= merge(ram_mem[wr_idx], write_memory_data, write_memory_mask);
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             push_req, push_ok, pop, ovf_clr, fifo_full, fifo_empty;

  assign fifo_full  = count_q == DEPTH_C;
  assign fifo_empty = count_q == '0;
  assign tx_valid   = !fifo_empty;
  // Gate the head so the output is a clean zero while empty/after reset.
  assign tx_data    = tx_valid ? fifo_mem[rd_ptr_q] : 8'h00;
  assign pop        = tx_valid && tx_ready;
  assign push_req   = wr_mmio && (wr_off == OFF_TXDATA) && (write_memory_mask[7:0] == 8'hFF);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign ovf_clr    = wr_mmio && (wr_off == OFF_STATUS) &&
                      write_memory_mask[2] && write_memory_data[2];

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr_q] <= write_memory_data[7:0];
  end

  // ---------------- timer ----------------
  logic [31:0] mtime_lo_q, mtime_hi_q, mtime_lo_d, mtime_hi_d;
  logic [63:0] mtimecmp_q, mtimecmp_d, mtime_inc;

  always_comb begin
    mtime_inc  = {mtime_hi_q, mtime_lo_q} + 64'd1;
    mtime_lo_d = mtime_inc[31:0];
    mtime_hi_d = mtime_inc[63:32];
    mtimecmp_d = mtimecmp_q;
    if (wr_mmio) begin
      case (wr_off)
        // Writing one half freezes carry between halves for this cycle.
        OFF_MTIME_LO: begin
          mtime_lo_d = merge(mtime_lo_q, write_memory_data, write_memory_mask);
          mtime_hi_d = mtime_hi_q;
        end
        OFF_MTIME_HI: begin
          mtime_hi_d = merge(mtime_hi_q, write_memory_data, write_memory_mask);
          mtime_lo_d = mtime_lo_q + 32'd1;
        end
        OFF_CMP_LO: mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], write_memory_data, write_memory_mask);
        OFF_CMP_HI: mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], write_memory_data, write_memory_mask);
        default: ;
      endcase
    end
  end

  assign timer_interrupt = {mtime_hi_q, mtime_lo_q} >= mtimecmp_q;

  // ---------------- MMIO state registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      mtime_lo_q <= '0;
      mtime_hi_q <= '0;
      mtimecmp_q <= '1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // A dropped push wins over a clear in the same cycle.
      if (push_req && !push_ok) overflow_q <= 1'b1;
      else if (ovf_clr)         overflow_q <= 1'b0;
      mtime_lo_q <= mtime_lo_d;
      mtime_hi_q <= mtime_hi_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  // ---------------- read mux (old values on same-cycle write) ----------------
  always_comb begin
    read_memory_data = '0;
    if (rd_ram) begin
      read_memory_data = ram_mem[rd_idx];
    end else if (rd_mmio) begin
      case (rd_off)
        OFF_STATUS:   read_memory_data = {16'h0000, 8'(count_q), 5'b00000,
                                          overflow_q, fifo_empty, fifo_full};
        OFF_MTIME_LO: read_memory_data = mtime_lo_q;
        OFF_MTIME_HI: read_memory_data = mtime_hi_q;
        OFF_CMP_LO:   read_memory_data = mtimecmp_q[31:0];
        OFF_CMP_HI:   read_memory_data = mtimecmp_q[63:32];
        default:      read_memory_data = '0;
      endcase
    end
  end

endmodule
